// File: rtl/i2c_regmap_pkg.sv
// ============================================================================
// Module      : i2c_regmap_pkg
// Description : Shared types and constants for the I2C register-map bridge:
//               controller state encoding, pointer width and the byte
//               returned for reads of unimplemented addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_regmap_pkg;

  localparam int         PTR_W        = 8;
  localparam logic [7:0] READ_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_PTR  = 3'd1,
    ST_WR_DATA  = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_HOLD  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_regmap.sv
// ============================================================================
// Module      : i2c_regmap
// Description : Bridges an I2C slave byte interface to a simple register
//               bus. The first written byte loads the register pointer,
//               following written bytes become register writes, and read
//               requests fetch bytes from the register at the pointer.
//               Register addresses beyond the implemented range drop
//               writes and read back as READ_DEFAULT.
// Config      : define I2C_REGMAP_AUTOINC_EN to advance the pointer after
//               every data byte; otherwise it only changes on pointer load.
// Ports       : clk, rst                     - clock, sync active-high reset
//               i_start/i_stop/i_read/i_write - one-cycle bus event pulses
//               i_write_valid/i_write_data/o_write_ready - received bytes
//               i_read_ready/o_read_valid/o_read_data    - bytes to transmit
//               o_reg_wr_en/o_reg_wr_addr/o_reg_wr_data  - register write
//               o_reg_rd_en/o_reg_rd_addr/i_reg_rd_data  - register read
//                 (i_reg_rd_data valid one cycle after o_reg_rd_en)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_regmap
  import i2c_regmap_pkg::*;
#(
  parameter int               NUM_REGS  = 16,
  parameter logic [PTR_W-1:0] RESET_PTR = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_read,
  input  logic             i_write,
  input  logic             i_write_valid,
  input  logic [7:0]       i_write_data,
  output logic             o_write_ready,
  input  logic             i_read_ready,
  output logic             o_read_valid,
  output logic [7:0]       o_read_data,
  output logic             o_reg_wr_en,
  output logic [PTR_W-1:0] o_reg_wr_addr,
  output logic [7:0]       o_reg_wr_data,
  output logic             o_reg_rd_en,
  output logic [PTR_W-1:0] o_reg_rd_addr,
  input  logic [7:0]       i_reg_rd_data
);

  // One extra bit so NUM_REGS = 256 compares correctly against an 8-bit ptr.
  localparam logic [PTR_W:0] c_NUM_REGS = (PTR_W + 1)'(NUM_REGS);

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_rd_pend;   // read phase active, waiting for i_read_ready
  logic             r_read_valid;
  logic [7:0]       r_read_data;
  logic             r_wr_en;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_rd_en;
  logic [PTR_W-1:0] r_rd_addr;

  logic             w_in_range;
  logic             w_wr_xfer;
  logic             w_bus_evt;
  logic [PTR_W-1:0] w_ptr_adv;

  assign w_in_range = ({1'b0, r_ptr} < c_NUM_REGS);
  assign w_wr_xfer  = i_write_valid && o_write_ready;
  assign w_bus_evt  = i_start || i_stop;

`ifdef I2C_REGMAP_AUTOINC_EN
  assign w_ptr_adv = r_ptr + 8'd1;
`else
  assign w_ptr_adv = r_ptr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= RESET_PTR;
      r_rd_pend    <= 1'b0;
      r_read_valid <= 1'b0;
      r_read_data  <= READ_DEFAULT;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_bus_evt) begin
            r_rd_pend <= 1'b0;
          end else if (i_write) begin
            r_rd_pend <= 1'b0;
            r_state   <= ST_GET_PTR;
          end else if (i_read || r_rd_pend) begin
            if (i_read_ready) begin
              r_rd_pend <= 1'b0;
              r_rd_en   <= w_in_range;
              r_rd_addr <= r_ptr;
              r_state   <= ST_RD_FETCH;
            end else begin
              r_rd_pend <= 1'b1;
            end
          end
        end
        ST_GET_PTR: begin
          if (w_wr_xfer) begin
            r_ptr <= i_write_data;
          end
          if (w_bus_evt) begin
            r_state <= ST_IDLE;
          end else if (w_wr_xfer) begin
            r_state <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          // A byte arriving together with stop/start is still written.
          if (w_wr_xfer) begin
            r_wr_en <= w_in_range;
            if (w_in_range) begin
              r_wr_addr <= r_ptr;
              r_wr_data <= i_write_data;
            end
            r_ptr <= w_ptr_adv;
          end
          if (w_bus_evt) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_FETCH: begin
          r_state <= w_bus_evt ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (w_bus_evt) begin
            r_state <= ST_IDLE;
          end else begin
            r_read_data  <= w_in_range ? i_reg_rd_data : READ_DEFAULT;
            r_read_valid <= 1'b1;
            r_state      <= ST_RD_HOLD;
          end
        end
        ST_RD_HOLD: begin
          if (w_bus_evt) begin
            // Abort: the fetched byte is discarded and ptr is left alone.
            r_read_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (i_read_ready) begin
            r_read_valid <= 1'b0;
            r_ptr        <= w_ptr_adv;
            r_rd_pend    <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_write_ready = (r_state == ST_GET_PTR) || (r_state == ST_WR_DATA);
  assign o_read_valid  = r_read_valid;
  assign o_read_data   = r_read_data;
  assign o_reg_wr_en   = r_wr_en;
  assign o_reg_wr_addr = r_wr_addr;
  assign o_reg_wr_data = r_wr_data;
  assign o_reg_rd_en   = r_rd_en;
  assign o_reg_rd_addr = r_rd_addr;

endmodule

`default_nettype wire

// File: tb/tb_i2c_regmap.sv
// ============================================================================
// Module      : tb_i2c_regmap
// Description : Self-checking bench for i2c_regmap. Stimulus tasks push the
//               expected register writes, register reads and returned bytes
//               into queues; a monitor on the falling edge pops and compares
//               them whenever the DUT strobes or hands over a byte.
//               Expected values follow I2C_REGMAP_AUTOINC_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_regmap;

  localparam int P_START = 0;
  localparam int P_STOP  = 1;
  localparam int P_READ  = 2;
  localparam int P_WRITE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start, i_stop, i_read, i_write;
  logic       i_write_valid;
  logic [7:0] i_write_data;
  logic       o_write_ready;
  logic       i_read_ready;
  logic       o_read_valid;
  logic [7:0] o_read_data;
  logic       o_reg_wr_en;
  logic [7:0] o_reg_wr_addr;
  logic [7:0] o_reg_wr_data;
  logic       o_reg_rd_en;
  logic [7:0] o_reg_rd_addr;
  logic [7:0] i_reg_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  int exp_wr[$];     // {addr, data}
  int exp_rd[$];     // addr
  int exp_rdata[$];  // byte handed over on read handshake

  i2c_regmap #(
    .NUM_REGS  (16),
    .RESET_PTR (8'h02)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_read        (i_read),
    .i_write       (i_write),
    .i_write_valid (i_write_valid),
    .i_write_data  (i_write_data),
    .o_write_ready (o_write_ready),
    .i_read_ready  (i_read_ready),
    .o_read_valid  (o_read_valid),
    .o_read_data   (o_read_data),
    .o_reg_wr_en   (o_reg_wr_en),
    .o_reg_wr_addr (o_reg_wr_addr),
    .o_reg_wr_data (o_reg_wr_data),
    .o_reg_rd_en   (o_reg_rd_en),
    .o_reg_rd_addr (o_reg_rd_addr),
    .i_reg_rd_data (i_reg_rd_data)
  );

  always #5 clk = ~clk;

  // Register file contents: 0x0E=0x11, 0x0F=0x22, otherwise 0x40+addr.
  function automatic logic [7:0] reg_model(input logic [7:0] a);
    if (a == 8'h0E) return 8'h11;
    if (a == 8'h0F) return 8'h22;
    return 8'h40 + a;
  endfunction

  always @(posedge clk) i_reg_rd_data <= reg_model(o_reg_rd_addr);

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (o_reg_wr_en) begin
        check("wr_rd_exclusive", int'(o_reg_rd_en), 0);
        e = (exp_wr.size() == 0) ? 32'hDEAD0000 : exp_wr.pop_front();
        check("reg_wr", {16'h0, o_reg_wr_addr, o_reg_wr_data}, e);
      end
      if (o_reg_rd_en) begin
        e = (exp_rd.size() == 0) ? 32'hDEAD0000 : exp_rd.pop_front();
        check("reg_rd_addr", int'(o_reg_rd_addr), e);
      end
      if (o_read_valid && i_read_ready) begin
        e = (exp_rdata.size() == 0) ? 32'hDEAD0000 : exp_rdata.pop_front();
        check("read_data", int'(o_read_data), e);
      end
    end
  end

  task automatic pulse(input int which);
    case (which)
      P_START: i_start = 1'b1;
      P_STOP:  i_stop  = 1'b1;
      P_READ:  i_read  = 1'b1;
      default: i_write = 1'b1;
    endcase
    @(posedge clk); #1;
    i_start = 1'b0; i_stop = 1'b0; i_read = 1'b0; i_write = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic with_stop);
    int cyc = 0;
    i_write_valid = 1'b1;
    i_write_data  = d;
    while (1) begin
      @(negedge clk);
      if (o_write_ready) break;
      cyc++;
      if (cyc > 20) begin
        check("write_ready_timeout", 0, 1);
        break;
      end
    end
    if (with_stop) i_stop = 1'b1;
    @(posedge clk); #1;
    i_write_valid = 1'b0;
    i_stop        = 1'b0;
  endtask

  task automatic set_ptr(input logic [7:0] p);
    pulse(P_START);
    pulse(P_WRITE);
    send_byte(p, 1'b0);
  endtask

  task automatic read_bytes(input int n);
    pulse(P_START);
    pulse(P_READ);
    for (int k = 0; k < n; k++) begin
      int lat = 0;
      i_read_ready = 1'b1;
      while (1) begin
        @(negedge clk);
        if (o_read_valid) break;
        lat++;
        if (lat > 20) break;
      end
      check("read_latency", lat, 3);
      @(posedge clk); #1;
      i_read_ready = 1'b0;
    end
    pulse(P_STOP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_start = 1'b0; i_stop = 1'b0; i_read = 1'b0; i_write = 1'b0;
    i_write_valid = 1'b0; i_write_data = 8'h00; i_read_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_write_ready", int'(o_write_ready), 0);
    check("rst_read_valid",  int'(o_read_valid), 0);
    check("rst_read_data",   int'(o_read_data), 8'hFF);
    check("rst_wr_en",       int'(o_reg_wr_en), 0);
    check("rst_rd_en",       int'(o_reg_rd_en), 0);
    check("rst_wr_addr",     int'(o_reg_wr_addr), 0);
    check("rst_wr_data",     int'(o_reg_wr_data), 0);
    check("rst_rd_addr",     int'(o_reg_rd_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // A: pointer 0x03 then two data bytes, then read back at the pointer.
`ifdef I2C_REGMAP_AUTOINC_EN
    exp_wr.push_back(32'h03A5); exp_wr.push_back(32'h045A);
    exp_rd.push_back(8'h05);    exp_rdata.push_back(8'h45);
`else
    exp_wr.push_back(32'h03A5); exp_wr.push_back(32'h035A);
    exp_rd.push_back(8'h03);    exp_rdata.push_back(8'h43);
`endif
    set_ptr(8'h03);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    pulse(P_STOP);
    read_bytes(1);

    // B: pointer 0x0E, repeated start, three reads crossing NUM_REGS.
`ifdef I2C_REGMAP_AUTOINC_EN
    exp_rd.push_back(8'h0E); exp_rd.push_back(8'h0F);
    exp_rdata.push_back(8'h11); exp_rdata.push_back(8'h22); exp_rdata.push_back(8'hFF);
`else
    exp_rd.push_back(8'h0E); exp_rd.push_back(8'h0E); exp_rd.push_back(8'h0E);
    exp_rdata.push_back(8'h11); exp_rdata.push_back(8'h11); exp_rdata.push_back(8'h11);
`endif
    set_ptr(8'h0E);
    read_bytes(3);

    // C: stop while the byte is held aborts it and keeps the pointer.
    exp_rd.push_back(8'h07);
    set_ptr(8'h07);
    pulse(P_STOP);
    pulse(P_START);
    pulse(P_READ);
    i_read_ready = 1'b1;
    @(posedge clk); #1;
    i_read_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_read_valid) break;
    end
    check("hold_valid_before_stop", int'(o_read_valid), 1);
    i_stop = 1'b1;
    @(posedge clk); #1;
    i_stop = 1'b0;
    @(negedge clk);
    check("abort_read_valid", int'(o_read_valid), 0);
    exp_rd.push_back(8'h07); exp_rdata.push_back(8'h47);
    read_bytes(1);

    // D: last in-range address, next byte out of range with coincident stop.
`ifdef I2C_REGMAP_AUTOINC_EN
    exp_wr.push_back(32'h0F3C);
    exp_rdata.push_back(8'hFF);
`else
    exp_wr.push_back(32'h0F3C); exp_wr.push_back(32'h0F4D);
    exp_rd.push_back(8'h0F);    exp_rdata.push_back(8'h22);
`endif
    set_ptr(8'h0F);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h4D, 1'b1);
    read_bytes(1);

    // E: pointer 0xFF (unimplemented) write dropped, pointer wraps.
`ifdef I2C_REGMAP_AUTOINC_EN
    exp_rd.push_back(8'h00); exp_rdata.push_back(8'h40);
`else
    exp_rdata.push_back(8'hFF);
`endif
    set_ptr(8'hFF);
    send_byte(8'h77, 1'b0);
    pulse(P_STOP);
    read_bytes(1);

    // F: reset during a data byte discards it and restores RESET_PTR.
    set_ptr(8'h05);
    i_write_valid = 1'b1;
    i_write_data  = 8'h99;
    rst           = 1'b1;
    @(posedge clk); #1;
    rst           = 1'b0;
    i_write_valid = 1'b0;
    @(negedge clk);
    check("post_rst_write_ready", int'(o_write_ready), 0);
    exp_rd.push_back(8'h02); exp_rdata.push_back(8'h42);
    read_bytes(1);

    repeat (5) @(posedge clk);
    check("wr_queue_left",    exp_wr.size(), 0);
    check("rd_queue_left",    exp_rd.size(), 0);
    check("rdata_queue_left", exp_rdata.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_regmap.md
I2C_REGMAP -- requirements
Module: i2c_regmap

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning number of implemented register addresses (1..256).
REQ-002 SHALL have parameter RESET_PTR, default 8'h00, meaning register pointer value after reset.
REQ-003 clk  input  1  sole clock; one clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start, stop, read, write  input  1 each  one-cycle event pulses from the I2C slave.
REQ-006 write_valid  input  1  slave holds a received byte; write_data  input  8  that byte; write_ready  output  1  byte accepted.
REQ-007 read_ready  input  1  slave requests next byte to transmit; read_valid  output  1  read_data valid; read_data  output  8  byte to transmit.
REQ-008 reg_wr_en  output  1; reg_wr_addr  output  8; reg_wr_data  output  8  register write strobe, address, data.
REQ-009 reg_rd_en  output  1; reg_rd_addr  output  8  register read strobe, address; reg_rd_data  input  8, valid exactly 1 cycle after reg_rd_en.

Function
REQ-010 SHALL implement states IDLE, GET_PTR, WR_DATA, RD_FETCH, RD_WAIT, RD_HOLD.
REQ-011 write pulse SHALL enter GET_PTR; read pulse SHALL enter RD_FETCH only if read_ready is high that cycle, else wait in IDLE-read until it rises.
REQ-012 write_ready SHALL be 1 in GET_PTR and WR_DATA, 0 elsewhere; byte transfers when write_valid && write_ready.
REQ-013 GET_PTR transfer SHALL load ptr <= write_data and enter WR_DATA; no register write.
REQ-014 WR_DATA transfer SHALL pulse reg_wr_en one cycle later with addr=ptr, data=write_data, then ptr <= ptr+1.
REQ-015 Addresses >= NUM_REGS: writes SHALL be dropped (no reg_wr_en) but ptr still advances; reads SHALL return 8'hFF without reg_rd_en.
REQ-016 ptr SHALL be 8 bits and wrap 8'hFF -> 8'h00.
REQ-017 RD_FETCH: reg_rd_en=1, reg_rd_addr=ptr for one cycle; RD_WAIT: capture reg_rd_data into read_data; RD_HOLD: read_valid=1.
REQ-018 Read latency: read_ready high in cycle N -> reg_rd_en in N+1 -> read_valid from N+3 until handshake.
REQ-019 read_valid && read_ready SHALL clear read_valid, increment ptr, return to RD_FETCH-wait for next read_ready.
REQ-020 stop or start SHALL return to IDLE; ptr SHALL be retained (write-ptr + repeated-start read works).
REQ-021 start/stop in RD_FETCH/RD_WAIT/RD_HOLD SHALL abort: read_valid cleared, no ptr increment.
REQ-022 write_valid transfer coincident with stop SHALL complete the register write before IDLE.
REQ-023 reg_wr_en and reg_rd_en SHALL never be high in the same cycle.

Reset
REQ-024 rst SHALL set state IDLE, ptr=RESET_PTR, write_ready=0, read_valid=0, read_data=8'hFF, reg_wr_en=0, reg_rd_en=0, reg_wr_addr=0, reg_wr_data=0, reg_rd_addr=0.
REQ-025 rst mid-transfer SHALL discard pending write or fetched read byte with no bus strobe afterward.

Configuration
REQ-026 Macro I2C_REGMAP_AUTOINC_EN defined: ptr increments per REQ-014/019.
REQ-027 Macro undefined: ptr changes only in GET_PTR; successive bytes hit the same address; REQ-016 unreachable.

Structure
REQ-028 Shared package i2c_regmap_pkg SHALL hold the state enum typedef, PTR_W=8, and READ_DEFAULT=8'hFF.
REQ-029 No sub-module; single flat module.

Verification
REQ-030 Write 0x03,0xA5,0x5A -> reg_wr_en twice: (0x03,0xA5),(0x04,0x5A); final ptr 0x05.
REQ-031 Write ptr 0x0E, repeated start, read 3 bytes with regs 0x0E=0x11,0x0F=0x22 -> read_data 0x11,0x22,0xFF; reg_rd_en for 0x0E,0x0F only.
REQ-032 Ptr 0xFF, write 0x77 (NUM_REGS=256) -> reg write (0xFF,0x77), ptr=0x00.
REQ-033 stop during RD_HOLD -> read_valid 0 next cycle, ptr unchanged.
REQ-034 Macro undefined: write 0x02,0x10,0x20 -> writes (0x02,0x10),(0x02,0x20).
REQ-035 rst asserted during WR_DATA with write_valid high -> no reg_wr_en, ptr=RESET_PTR.
